zxuno_regbus_arbiter: RTL and testbench

Shares the ZX-UNO internal register bus (zxuno_addr / zxuno_regrd / zxuno_regwr / din, with dout/oe returned from the register blocks such as device options) between the Z80 port interface and one auxiliary master (on-screen config menu, hotkey handler, boot loader). The CPU always has absolute priority and zero-latency pass-through. Auxiliary accesses use a 4-phase req/ack handshake and are slotted into bus-quiet cycles only, after a guard interval.

---
 rtl/zxuno_regbus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_zxuno_regbus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zxuno_regbus_arbiter.sv
// Purpose: shares the ZX-UNO internal register bus between the Z80 port path and one aux master.
// Latency: CPU 0 cycles (pure combinational pass-through); aux access >= 2 cycles request-to-strobe, ack one cycle later.
// Backpressure: CPU is never stalled; aux waits (aux_busy=1) until GUARD_CYCLES quiet cycles, indefinitely if needed.
//
// Ports:
//   clk, rst_n                  system clock, synchronous active-low reset
//   cpu_addr/regrd/regwr/din    CPU-side register access, forwarded to the shared bus with zero latency
//   cpu_dout, cpu_oe            read data returned to the CPU (oe masked during aux-owned cycles)
//   aux_req/we/addr/wdata       aux request, 4-phase handshake; fields latched when the request is accepted
//   aux_ack, aux_rdata          aux acknowledge and read result (valid while aux_ack=1)
//   aux_busy                    request accepted but not yet acknowledged
//   zxuno_addr/regrd/regwr      shared bus address and strobes
//   bus_din                     shared bus write data
//   bus_dout, bus_oe            OR-combined read data / output enable from the register blocks

module zxuno_regbus_arbiter #(
  // Consecutive CPU-idle cycles needed before an aux access may issue (1..15).
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_regrd,
  input  logic       cpu_regwr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_oe,
  input  logic       aux_req,
  input  logic       aux_we,
  input  logic [7:0] aux_addr,
  input  logic [7:0] aux_wdata,
  output logic       aux_ack,
  output logic [7:0] aux_rdata,
  output logic       aux_busy,
  output logic [7:0] zxuno_addr,
  output logic       zxuno_regrd,
  output logic       zxuno_regwr,
  output logic [7:0] bus_din,
  input  logic [7:0] bus_dout,
  input  logic       bus_oe
);

  localparam logic [3:0] GUARD = 4'(GUARD_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       cpu_act;
  logic       aux_own;
  logic [3:0] cnt;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] rdata_q;

  // Any CPU strobe claims the bus in the same cycle; never registered.
  assign cpu_act = cpu_regrd | cpu_regwr;

  // Quiet-bus counter: counts CPU-idle cycles, saturating at GUARD so that
  // cnt==GUARD means "at least GUARD idle cycles have just elapsed".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cpu_act) begin
      cnt <= '0;
    end else if (cnt < GUARD) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Request latch: fields are frozen at acceptance, so the aux master may
  // change them freely afterwards without affecting the access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_we    <= 1'b0;
      req_addr  <= 8'h00;
      req_wdata <= 8'h00;
    end else if (state == S_IDLE && aux_req) begin
      req_we    <= aux_we;
      req_addr  <= aux_addr;
      req_wdata <= aux_wdata;
    end
  end

  // Aux read result: only updated by an aux read that actually owned the bus.
  // Nobody driving the bus reads back as all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= 8'hFF;
    end else if (aux_own && !req_we) begin
      rdata_q <= bus_oe ? bus_dout : 8'hFF;
    end
  end

  assign aux_rdata = rdata_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (aux_req) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == GUARD && !cpu_act) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A CPU strobe landing in the issue slot wins; the aux access is
        // dropped without a strobe and retried after a fresh guard interval.
        state_nxt = cpu_act ? S_WAIT : S_DONE;
      end
      S_DONE: begin
        if (!aux_req) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and bus mux.
  always_comb begin
    aux_own     = (state == S_ISSUE) && !cpu_act;
    zxuno_addr  = cpu_addr;
    zxuno_regrd = cpu_regrd;
    zxuno_regwr = cpu_regwr;
    bus_din     = cpu_din;
    if (aux_own) begin
      zxuno_addr  = req_addr;
      zxuno_regrd = ~req_we;
      zxuno_regwr = req_we;
      bus_din     = req_wdata;
    end
    // Aux read data must never look like a CPU read response.
    cpu_oe   = bus_oe & ~aux_own;
    aux_ack  = (state == S_DONE);
    aux_busy = (state == S_WAIT) || (state == S_ISSUE);
  end

  assign cpu_dout = bus_dout;

endmodule

// File: tb/tb_zxuno_regbus_arbiter.sv
`timescale 1ns/1ps
module tb_zxuno_regbus_arbiter;

  localparam int G = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] cpu_addr, cpu_din, cpu_dout;
  logic       cpu_regrd, cpu_regwr, cpu_oe;
  logic       aux_req, aux_we, aux_ack, aux_busy;
  logic [7:0] aux_addr, aux_wdata, aux_rdata;
  logic [7:0] zxuno_addr, bus_din, bus_dout;
  logic       zxuno_regrd, zxuno_regwr, bus_oe;

  zxuno_regbus_arbiter #(.GUARD_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_regrd(cpu_regrd), .cpu_regwr(cpu_regwr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_oe(cpu_oe),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata), .aux_busy(aux_busy),
    .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd), .zxuno_regwr(zxuno_regwr),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe)
  );

  typedef struct {
    logic       rst_n;
    logic       crd, cwr;
    logic [7:0] caddr, cdin;
    logic       req, we;
    logic [7:0] aaddr, awd, bdout;
    logic       boe;
    logic [7:0] zaddr;
    logic       zrd, zwr;
    logic [7:0] zdin;
    logic       coe, ack, busy;
    logic [7:0] rdata;
  } vec_t;

  vec_t vec [21];
  vec_t cur;

  int checks = 0;
  int errors = 0;

  // Reference model: an aux access is pending from the cycle after its
  // request is accepted; it strobes in the first cycle at least 2 cycles
  // after acceptance whose trailing window of G+2 cycles is entirely
  // CPU-idle (G quiet cycles, the issuing decision cycle, the strobe cycle).
  int         phase = 0;   // 0 idle, 1 pending, 2 acknowledged
  int         age = 0;
  int         run = 0;     // CPU-idle cycles since reset/last CPU strobe
  logic       m_we = 1'b0;
  logic [7:0] m_addr = 8'h00, m_wdata = 8'h00, m_rdata = 8'hFF;
  int         cyc = 0, strobes = 0, acks = 0, last_strobe = -1;
  logic       prev_obs = 1'b0, prev_ack = 1'b0;
  logic       chk_on = 1'b0, tbl_on = 1'b0;
  logic [7:0] s_zaddr, s_din, s_rdata;
  logic       s_zrd, s_zwr, s_ack, s_busy;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // One clock: inputs already driven; compare at negedge, return at posedge+1.
  task automatic tick();
    logic        act, es, obs;
    int          run_incl;
    logic [7:0]  e_addr, e_din;
    logic        e_rd, e_wr;
    logic [63:0] got, exp;
    @(negedge clk);
    act      = cpu_regrd | cpu_regwr;
    run_incl = act ? 0 : run + 1;
    if (phase == 1) age++;
    es     = (phase == 1) && (age >= 2) && (run_incl >= G + 2);
    e_addr = es ? m_addr : cpu_addr;
    e_rd   = es ? ~m_we : cpu_regrd;
    e_wr   = es ? m_we : cpu_regwr;
    e_din  = es ? m_wdata : cpu_din;
    s_zaddr = zxuno_addr; s_zrd = zxuno_regrd; s_zwr = zxuno_regwr; s_din = bus_din;
    s_ack = aux_ack; s_busy = aux_busy; s_rdata = aux_rdata;
    obs = (zxuno_regrd | zxuno_regwr) & ~act;
    got = {27'd0, zxuno_addr, zxuno_regrd, zxuno_regwr, bus_din, cpu_oe, cpu_dout, aux_ack, aux_busy, aux_rdata};
    if (chk_on) begin
      exp = {27'd0, e_addr, e_rd, e_wr, e_din, bus_oe & ~es, bus_dout, 1'(phase == 2), 1'(phase == 1), m_rdata};
      check("cycle_model", got, exp);
      if (obs) begin
        check("strobe_one_cycle", {63'd0, prev_obs}, 64'd0);
        check("strobe_guard", {63'd0, 1'(run_incl - 1 >= G)}, 64'd1);
      end
      if (tbl_on) begin
        exp = {27'd0, cur.zaddr, cur.zrd, cur.zwr, cur.zdin, cur.coe, cur.bdout, cur.ack, cur.busy, cur.rdata};
        check("table", got, exp);
      end
    end
    if (obs) begin strobes++; last_strobe = cyc; end
    if (aux_ack === 1'b1 && prev_ack !== 1'b1) acks++;
    prev_obs = obs;
    prev_ack = aux_ack;
    if (!rst_n) begin
      phase = 0; m_rdata = 8'hFF; m_we = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
    end else if (phase == 1 && es) begin
      phase = 2;
      if (!m_we) m_rdata = bus_oe ? bus_dout : 8'hFF;
    end else if (phase == 2 && !aux_req) begin
      phase = 0;
    end else if (phase == 0 && aux_req) begin
      phase = 1; age = 0; m_we = aux_we; m_addr = aux_addr; m_wdata = aux_wdata;
    end
    run = rst_n ? run_incl : 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    cpu_regrd = rd; cpu_regwr = wr; cpu_addr = a; cpu_din = d;
  endtask

  task automatic rand_traffic();
    int r;
    r = $urandom_range(0, 9);
    cpu_regrd = (r < 2);
    cpu_regwr = (r == 2);
    cpu_addr  = 8'($urandom);
    cpu_din   = 8'($urandom);
    bus_dout  = 8'($urandom);
    bus_oe    = 1'($urandom);
    aux_we    = 1'($urandom);
    aux_addr  = 8'($urandom);
    aux_wdata = 8'($urandom);
  endtask

  task automatic wait_ack(input int limit);
    for (int k = 0; k < limit; k++) begin
      tick();
      if (s_ack) break;
    end
  endtask

  initial begin
    int a, st, st_a;
    logic got;

    // rst  crd cwr caddr  cdin   req we aaddr  awd    bdout  boe | zaddr zrd zwr zdin   coe ack busy rdata
    vec[0]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hFF};
    vec[1]  = vec[0];
    vec[2]  = vec[0];
    vec[3]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b1, 8'h0E, 8'h55, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hFF};
    vec[4]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hFF};
    vec[5]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h1A, 1'b1, 8'h0E, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'hFF};
    vec[6]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hFF};
    vec[7]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hFF};
    vec[8]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h1A, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hFF};
    vec[9]  = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h0F, 8'h99, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hFF};
    vec[10] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h0F, 8'h99, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hFF};
    vec[11] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h0F, 8'h99, 8'h1A, 1'b1, 8'h0F, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 8'hFF};
    vec[12] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h0F, 8'h99, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h1A};
    vec[13] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h1A};
    vec[14] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h0F, 8'h00, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h1A};
    vec[15] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h0F, 8'h00, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h1A};
    vec[16] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h0F, 8'h00, 8'h1A, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1A};
    vec[17] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'hFF};
    vec[18] = '{1'b1, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h1A, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hFF};
    vec[19] = '{1'b1, 1'b1, 1'b0, 8'h0E, 8'h28, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 1'b1, 8'h0E, 1'b1, 1'b0, 8'h28, 1'b1, 1'b0, 1'b0, 8'hFF};
    vec[20] = '{1'b1, 1'b0, 1'b1, 8'h0F, 8'h28, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 1'b0, 8'h0F, 1'b0, 1'b1, 8'h28, 1'b0, 1'b0, 1'b0, 8'hFF};

    rst_n = 1'b0; set_cpu(1'b0, 1'b0, 8'hA5, 8'h3C);
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = 8'h00; aux_wdata = 8'h00;
    bus_dout = 8'h1A; bus_oe = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    chk_on = 1'b1;

    // Table-driven: reset state, best-case aux write, aux reads with oe=1/0, CPU pass-through.
    tbl_on = 1'b1;
    for (int i = 0; i < 21; i++) begin
      cur = vec[i];
      rst_n = cur.rst_n; set_cpu(cur.crd, cur.cwr, cur.caddr, cur.cdin);
      aux_req = cur.req; aux_we = cur.we; aux_addr = cur.aaddr; aux_wdata = cur.awd;
      bus_dout = cur.bdout; bus_oe = cur.boe;
      tick();
    end
    tbl_on = 1'b0;

    // CPU write concurrent with a pending aux write; aux_req dropped early.
    set_cpu(1'b0, 1'b0, 8'hA5, 8'h3C); aux_req = 1'b0; bus_oe = 1'b0;
    repeat (3) tick();
    st = strobes; a = cyc;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h0E; aux_wdata = 8'h55;
    set_cpu(1'b0, 1'b1, 8'h0E, 8'h28);
    tick();
    check("concur_cpu_addr", 64'(s_zaddr), 64'h0E);
    check("concur_cpu_din", 64'(s_din), 64'h28);
    check("concur_cpu_wr", 64'(s_zwr), 64'd1);
    set_cpu(1'b0, 1'b0, 8'hA5, 8'h3C); aux_req = 1'b0; aux_addr = 8'h00; aux_wdata = 8'h00;
    tick();
    set_cpu(1'b0, 1'b1, 8'h0E, 8'h28);
    tick();
    set_cpu(1'b0, 1'b0, 8'hA5, 8'h3C);
    wait_ack(20);
    check("concur_ack", 64'(s_ack), 64'd1);
    check("concur_strobes", 64'(strobes - st), 64'd1);
    check("concur_strobe_cycle", 64'(last_strobe - a), 64'd6);
    tick();

    // CPU strobe lands in the ISSUE cycle: aborted, retried with one strobe.
    repeat (3) tick();
    st = strobes; a = cyc;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h21; aux_wdata = 8'h42;
    tick(); tick();
    set_cpu(1'b0, 1'b1, 8'h33, 8'h44);
    tick();
    check("abort_cpu_addr", 64'(s_zaddr), 64'h33);
    check("abort_cpu_din", 64'(s_din), 64'h44);
    check("abort_no_rd", 64'(s_zrd), 64'd0);
    check("abort_no_strobe", 64'(strobes - st), 64'd0);
    set_cpu(1'b0, 1'b0, 8'hA5, 8'h3C);
    wait_ack(20);
    check("abort_ack", 64'(s_ack), 64'd1);
    check("abort_strobes", 64'(strobes - st), 64'd1);
    check("abort_strobe_cycle", 64'(last_strobe - a), 64'd6);
    aux_req = 1'b0; tick(); tick();

    // Reset while in DONE after a read.
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'h0F; bus_oe = 1'b1; bus_dout = 8'h5A;
    wait_ack(20);
    check("done_rdata", 64'(s_rdata), 64'h5A);
    tick();
    rst_n = 1'b0; aux_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_done_ack", 64'(s_ack), 64'd0);
    check("rst_done_busy", 64'(s_busy), 64'd0);
    check("rst_done_rdata", 64'(s_rdata), 64'hFF);

    // Reset while in WAIT: the killed request never strobes.
    repeat (3) tick();
    aux_req = 1'b1; aux_we = 1'b0; bus_dout = 8'hC3;
    wait_ack(20);
    aux_req = 1'b0; tick();
    check("pre_wait_rdata", 64'(s_rdata), 64'hC3);
    st = strobes;
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h0E; aux_wdata = 8'h66;
    set_cpu(1'b1, 1'b0, 8'h10, 8'h00);
    repeat (4) tick();
    check("wait_busy", 64'(s_busy), 64'd1);
    rst_n = 1'b0; aux_req = 1'b0; set_cpu(1'b0, 1'b0, 8'hA5, 8'h3C);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_wait_ack", 64'(s_ack), 64'd0);
    check("rst_wait_busy", 64'(s_busy), 64'd0);
    check("rst_wait_rdata", 64'(s_rdata), 64'hFF);
    repeat (8) tick();
    check("rst_wait_no_strobe", 64'(strobes - st), 64'd0);

    // Random CPU traffic with 100 aux requests.
    st = strobes; st_a = acks;
    for (int n = 0; n < 100; n++) begin
      aux_req = 1'b0;
      repeat ($urandom_range(0, 3)) begin rand_traffic(); tick(); end
      rand_traffic(); aux_req = 1'b1;
      tick();
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
        rand_traffic();
        if ($urandom_range(0, 19) == 0) aux_req = 1'b0;
        tick();
        got = s_ack;
      end
      check("rand_ack_seen", 64'(got), 64'd1);
      repeat ($urandom_range(0, 2)) begin rand_traffic(); tick(); end
      aux_req = 1'b0;
      for (int k = 0; k < 10; k++) begin
        rand_traffic();
        tick();
        if (!s_ack) break;
      end
    end
    check("rand_strobes", 64'(strobes - st), 64'd100);
    check("rand_acks", 64'(acks - st_a), 64'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
